// File: rtl/alu_lab_pkg.sv
// Shared types and constants for the ALU result capture lab: control FSM states,
// history depth and active-low seven-segment glyphs (bit 0 = segment a).
package alu_lab_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    localparam int HIST_DEPTH = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
        case (digit)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            4'hF:    return SEG_F;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex7seg
    import alu_lab_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Glyph lookup
    always_comb begin
        seg = seg_glyph(digit);
    end

endmodule

// File: rtl/alu_result_capture.sv
// Debounced capture of the ALU result into a 4-deep history, with the selected
// entry shown on two active-low seven-segment digits.
module alu_result_capture
    import alu_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] alu_out,
    input  logic       capture_raw,
    input  logic       clear,
    input  logic [1:0] sel,
    output logic [6:0] hex_lo,
    output logic [6:0] hex_hi,
    output logic [2:0] count,
    output logic       capture_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       CNT_FULL = 3'(HIST_DEPTH);

    logic             sync1_r;
    logic             sync2_r;
    state_t           state_r;
    logic [CNT_W-1:0] deb_cnt_r;
    logic             capture_pulse_r;
    logic [7:0]       hist_r [HIST_DEPTH];
    logic [2:0]       count_r;
    logic [7:0]       shown_s;
    logic             show_s;
    logic [6:0]       glyph_lo_s;
    logic [6:0]       glyph_hi_s;

    // Two-flop synchronizer for the bouncy key input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= capture_raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce FSM: one strobe per stable press, re-armed only by a low sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            deb_cnt_r       <= CNT_ZERO;
            capture_pulse_r <= 1'b0;
        end else begin
            capture_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sync2_r) begin
                        state_r   <= ST_DEBOUNCE;
                        deb_cnt_r <= CNT_ONE;
                    end else begin
                        deb_cnt_r <= CNT_ZERO;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!sync2_r) begin
                        state_r   <= ST_IDLE;
                        deb_cnt_r <= CNT_ZERO;
                    end else if (deb_cnt_r + CNT_ONE == CNT_LAST) begin
                        state_r         <= ST_HELD;
                        deb_cnt_r       <= CNT_ZERO;
                        capture_pulse_r <= 1'b1;
                    end else begin
                        deb_cnt_r <= deb_cnt_r + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!sync2_r) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_HELD;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    deb_cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    // History shift register; clear takes priority over a coincident capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) hist_r[i] <= 8'h00;
            count_r <= 3'd0;
        end else if (clear) begin
            for (int i = 0; i < HIST_DEPTH; i++) hist_r[i] <= 8'h00;
            count_r <= 3'd0;
        end else if (capture_pulse_r) begin
            for (int i = HIST_DEPTH - 1; i > 0; i--) hist_r[i] <= hist_r[i-1];
            hist_r[0] <= alu_out;
            count_r   <= (count_r == CNT_FULL) ? count_r : count_r + 3'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Select the displayed entry; indices at or beyond count are blanked
    always_comb begin
        shown_s = hist_r[sel];
        if ({1'b0, sel} < count_r) begin
            show_s = 1'b1;
        end else begin
            show_s = 1'b0;
        end
    end

    hex7seg u_hex_lo (.digit(shown_s[3:0]), .seg(glyph_lo_s));
    hex7seg u_hex_hi (.digit(shown_s[7:4]), .seg(glyph_hi_s));

    // Blanking mux on the decoded glyphs
    always_comb begin
        if (show_s) begin
            hex_lo = glyph_lo_s;
            hex_hi = glyph_hi_s;
        end else begin
            hex_lo = SEG_BLANK;
            hex_hi = SEG_BLANK;
        end
    end

    assign count         = count_r;
    assign capture_pulse = capture_pulse_r;

endmodule

// File: tb/tb_alu_result_capture.sv
// Randomized self-checking bench for alu_result_capture with a queue-based
// reference model of the capture history.
module tb_alu_result_capture;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] alu_out = 8'h00;
    logic       capture_raw = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [6:0] hex_lo;
    logic [6:0] hex_hi;
    logic [2:0] count;
    logic       capture_pulse;

    int checks = 0;
    int failures = 0;
    logic [7:0] model_q[$];

    alu_result_capture #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .reset_n(reset_n), .alu_out(alu_out), .capture_raw(capture_raw),
        .clear(clear), .sel(sel), .hex_lo(hex_lo), .hex_hi(hex_hi),
        .count(count), .capture_pulse(capture_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [13:0] model_display(input int s);
        logic [7:0] v;
        if (s < model_q.size()) begin
            v = model_q[s];
            return {glyph(v[7:4]), glyph(v[3:0])};
        end
        return {7'h7F, 7'h7F};
    endfunction

    function automatic void model_capture(input logic [7:0] v);
        model_q.push_front(v);
        if (model_q.size() > 4) void'(model_q.pop_back());
    endfunction

    // Drives one press of len edges; optionally pulses clear in the expected strobe cycle
    task automatic run_press(input logic [7:0] v, input int len, input bit clr_in_pulse,
                             output int npulse, output int first_k);
        @(posedge clk); #1;
        alu_out = v;
        capture_raw = 1'b1;
        npulse = 0;
        first_k = -1;
        for (int k = 1; k <= len + N + 6; k++) begin
            @(posedge clk); #1;
            if (capture_pulse === 1'b1) begin
                npulse++;
                if (first_k < 0) first_k = k;
            end
            if (k == len) capture_raw = 1'b0;
            if (clr_in_pulse && k == N + 2) clear = 1'b1;
            if (k == N + 3) clear = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        sel = 2'd0;
        @(posedge clk); #1;
        checks++;
        if (count !== 3'd0 || hex_hi !== 7'h7F || hex_lo !== 7'h7F || capture_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: count=%0d hex_hi=%h hex_lo=%h pulse=%b, want 0/7f/7f/0",
                     count, hex_hi, hex_lo, capture_pulse);
        end
        model_q.delete();
    endtask

    task automatic test_basic;
        int np, fk;
        run_press(8'h3A, 10, 1'b0, np, fk);
        model_capture(8'h3A);
        sel = 2'd0; #1;
        checks++;
        if (np !== 1 || fk !== N + 2) begin
            failures++;
            $display("FAIL basic_pulse: pulses=%0d at=%0d, want 1 at %0d", np, fk, N + 2);
        end
        checks++;
        if (count !== 3'd1 || hex_hi !== 7'h30 || hex_lo !== 7'h08) begin
            failures++;
            $display("FAIL basic_display: count=%0d hi=%h lo=%h, want 1/30/08", count, hex_hi, hex_lo);
        end
        sel = 2'd1; #1;
        checks++;
        if (hex_hi !== 7'h7F || hex_lo !== 7'h7F) begin
            failures++;
            $display("FAIL basic_blank_sel1: hi=%h lo=%h, want 7f/7f", hex_hi, hex_lo);
        end
    endtask

    task automatic test_bounce;
        logic [5:0] pat;
        int np;
        logic [2:0] cnt_before;
        pat = 6'b011011;
        cnt_before = count;
        np = 0;
        alu_out = 8'hEE;
        for (int k = 0; k < 6 + N + 6; k++) begin
            @(posedge clk); #1;
            capture_raw = (k < 6) ? pat[k] : 1'b0;
            if (capture_pulse === 1'b1) np++;
        end
        checks++;
        if (np !== 0 || count !== cnt_before) begin
            failures++;
            $display("FAIL bounce: pulses=%0d count=%0d, want 0 and %0d", np, count, cnt_before);
        end
    endtask

    task automatic test_fill;
        int np, fk;
        logic [13:0] exp_d;
        for (int i = 1; i <= 5; i++) begin
            run_press(8'(i), N + 1, 1'b0, np, fk);
            model_capture(8'(i));
            checks++;
            if (np !== 1 || fk !== N + 2) begin
                failures++;
                $display("FAIL fill_pulse%0d: pulses=%0d at=%0d, want 1 at %0d", i, np, fk, N + 2);
            end
        end
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("FAIL fill_count: count=%0d, want 4", count);
        end
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); #1;
            exp_d = {glyph(4'h0), glyph(4'(5 - s))};
            checks++;
            if ({hex_hi, hex_lo} !== exp_d) begin
                failures++;
                $display("FAIL fill_sel%0d: hi=%h lo=%h, want %h/%h", s, hex_hi, hex_lo, exp_d[13:7], exp_d[6:0]);
            end
        end
    endtask

    task automatic test_clear_in_pulse;
        int np, fk;
        run_press(8'hC7, N + 2, 1'b1, np, fk);
        model_q.delete();
        checks++;
        if (np !== 1 || count !== 3'd0) begin
            failures++;
            $display("FAIL clear_in_pulse: pulses=%0d count=%0d, want 1 and 0", np, count);
        end
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); #1;
            checks++;
            if (hex_hi !== 7'h7F || hex_lo !== 7'h7F) begin
                failures++;
                $display("FAIL clear_blank_sel%0d: hi=%h lo=%h, want 7f/7f", s, hex_hi, hex_lo);
            end
        end
    endtask

    task automatic test_reset_in_held;
        int np, fk;
        @(posedge clk); #1;
        alu_out = 8'h5D;
        capture_raw = 1'b1;
        np = 0;
        repeat (N + 4) begin
            @(posedge clk); #1;
            if (capture_pulse === 1'b1) np++;
        end
        model_capture(8'h5D);
        reset_n = 1'b0;
        #1;
        model_q.delete();
        checks++;
        if (np !== 1 || count !== 3'd0 || hex_lo !== 7'h7F || capture_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_held: pulses=%0d count=%0d lo=%h, want 1/0/7f", np, count, hex_lo);
        end
        alu_out = 8'h9B;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        np = 0;
        fk = -1;
        for (int k = 1; k <= N + 8; k++) begin
            @(posedge clk); #1;
            if (capture_pulse === 1'b1) begin
                np++;
                if (fk < 0) fk = k;
            end
        end
        capture_raw = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model_capture(8'h9B);
        sel = 2'd0; #1;
        checks++;
        if (np !== 1 || fk !== N + 2 || count !== 3'd1 || {hex_hi, hex_lo} !== model_display(0)) begin
            failures++;
            $display("FAIL post_reset_press: pulses=%0d at=%0d count=%0d hi=%h lo=%h, want 1 at %0d, count 1",
                     np, fk, count, hex_hi, hex_lo, N + 2);
        end
    endtask

    task automatic test_random;
        int np, fk, len;
        logic [7:0] v;
        logic [13:0] exp_d;
        for (int it = 0; it < 14; it++) begin
            v = 8'($urandom);
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
                clear = 1'b1;
                @(posedge clk); #1;
                clear = 1'b0;
                model_q.delete();
            end
            run_press(v, len, 1'b0, np, fk);
            if (len >= N) model_capture(v);
            checks++;
            if ((len >= N && (np !== 1 || fk !== N + 2)) || (len < N && np !== 0)) begin
                failures++;
                $display("FAIL rand_pulse it=%0d len=%0d: pulses=%0d at=%0d", it, len, np, fk);
            end
            checks++;
            if (count !== 3'(model_q.size())) begin
                failures++;
                $display("FAIL rand_count it=%0d: count=%0d, want %0d", it, count, model_q.size());
            end
            for (int s = 0; s < 4; s++) begin
                sel = 2'(s); #1;
                exp_d = model_display(s);
                checks++;
                if ({hex_hi, hex_lo} !== exp_d) begin
                    failures++;
                    $display("FAIL rand_display it=%0d sel=%0d: hi=%h lo=%h, want %h/%h",
                             it, s, hex_hi, hex_lo, exp_d[13:7], exp_d[6:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounce();
        test_fill();
        test_clear_in_pulse();
        test_reset_in_held();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_capture.md
ALU_RESULT_CAPTURE -- requirements
Module: alu_result_capture

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16, consecutive synchronized-high samples required to accept a capture request (legal range 2..255).
REQ-002 Port: clk  input  1  single system clock (CLOCK_50 at top level); all state changes on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: alu_out  input  8  result bus from the ALU stage; sampled only on an accepted capture.
REQ-005 Port: capture_raw  input  1  asynchronous active-high capture request (inverted KEY); bouncy, unsynchronized.
REQ-006 Port: clear  input  1  synchronous active-high history clear.
REQ-007 Port: sel  input  2  history index to display; 0 = newest.
REQ-008 Port: hex_lo  output  7  active-low seven-segment pattern for alu_out[3:0] of the selected entry.
REQ-009 Port: hex_hi  output  7  active-low seven-segment pattern for alu_out[7:4] of the selected entry.
REQ-010 Port: count  output  3  number of valid history entries, 0..4.
REQ-011 Port: capture_pulse  output  1  one-cycle strobe on each accepted capture.

Function
REQ-012 capture_raw shall pass through a two-flop synchronizer before any other use.
REQ-013 Control FSM states: IDLE, DEBOUNCE, HELD.
REQ-014 IDLE -> DEBOUNCE when synchronized request is 1; debounce counter loads 1.
REQ-015 DEBOUNCE: synchronized 1 increments counter; synchronized 0 returns to IDLE with counter cleared.
REQ-016 DEBOUNCE -> HELD on the edge where counter reaches DEBOUNCE_CYCLES; capture_pulse = 1 for exactly that following cycle.
REQ-017 HELD -> IDLE only after synchronized request is 0 for one sample; no further capture while held (one capture per press).
REQ-018 Latency: capture_pulse asserts DEBOUNCE_CYCLES+2 cycles after capture_raw goes stably high (2 sync + debounce).
REQ-019 History: 4 entries x 8 bits; on capture, entry[i+1] <= entry[i] for i=0..2, entry[0] <= alu_out sampled in the capture_pulse cycle.
REQ-020 count increments on capture, saturating at 4; capture when full discards oldest entry, count stays 4.
REQ-021 clear sets all entries to 0 and count to 0 next edge; clear and capture in same cycle: clear wins, capture discarded.
REQ-022 clear shall not affect FSM state; a press in progress continues but its capture is lost if coincident with clear.
REQ-023 Display: if sel < count, hex_hi/hex_lo show hex digits 0-F of entry[sel]; otherwise both = 7'h7F (blank).
REQ-024 Display outputs combinational from registered history, count and sel; no added latency.
REQ-025 Segment encoding bit 0 = segment a ... bit 6 = segment g, active-low, standard 0-F glyphs (b, d lowercase).

Reset
REQ-026 reset_n low: FSM = IDLE, debounce counter = 0, synchronizer flops = 0, all entries = 0, count = 0, capture_pulse = 0; hex_hi/hex_lo therefore 7'h7F.
REQ-027 Reset asserted mid-debounce or mid-hold aborts the press; after release a new full debounce is required.
REQ-028 Reset deassertion is assumed synchronized at top level; block shall not require extra cycles after release.

Structure
REQ-029 Shared package alu_lab_pkg holds: FSM state enum, HIST_DEPTH = 4, SEG_BLANK = 7'h7F, 16-entry segment glyph constants.
REQ-030 One sub-module hex7seg (4-bit in, 7-bit active-low out, combinational), instantiated twice.
REQ-031 Debounce counter width = $clog2(DEBOUNCE_CYCLES+1).

Verification (DEBOUNCE_CYCLES = 4)
REQ-032 Reset then sel=0 -> count=0, hex_hi=hex_lo=7'h7F, capture_pulse=0.
REQ-033 alu_out=8'h3A, capture_raw held high 10 cycles -> capture_pulse one cycle at cycle 6, count=1, hex_hi=7'h30 ("3"), hex_lo=7'h08 ("A").
REQ-034 Bounce: capture_raw high 2, low 1, high 2, then low -> no capture_pulse, count unchanged.
REQ-035 Five presses with alu_out 01,02,03,04,05 -> count=4; sel 0..3 show 05,04,03,02; 01 discarded.
REQ-036 clear asserted in the capture_pulse cycle -> count=0, all displays blank, no entry written.
REQ-037 reset_n pulsed low during HELD, capture_raw still high -> no capture until release and a fresh 4-cycle stable press.
